key_cmd_scheduler: RTL

KEY_CMD_SCHEDULER -- requirements
Module: key_cmd_scheduler

---
 rtl/key_cmd_scheduler_if.sv | 28 ++
 rtl/key_cmd_scheduler.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_cmd_scheduler_if.sv
// key_cmd_scheduler_if
//   Groups the keyboard-event inputs and the command handshake of the key
//   command scheduler into one bundle.
//   key_valid   : one-cycle pulse marking a decoded key event
//   last_change : {extend, scancode} of that event
//   key_down    : held-key bitmap, already updated in the key_valid cycle
//   cmd_ready   : game engine accepts the head command
//   cmd_valid   : head command available
//   cmd_dir     : head direction (00 up, 01 down, 10 left, 11 right)
//   master = keyboard decoder / game engine side, slave = scheduler side.
interface key_cmd_scheduler_if;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         cmd_ready;
  logic         cmd_valid;
  logic [1:0]   cmd_dir;

  modport master (
    output key_valid, last_change, key_down, cmd_ready,
    input  cmd_valid, cmd_dir
  );

  modport slave (
    input  key_valid, last_change, key_down, cmd_ready,
    output cmd_valid, cmd_dir
  );
endinterface

// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler
//   Turns keyboard make/break events into a queue of direction commands for
//   the game engine, runs the IDLE/RUN/PAUSE game state machine and generates
//   auto-repeat for a held direction key.
//   clk         : system clock, rising edge
//   rst         : synchronous, active-low reset
//   bus         : key event inputs and command handshake (slave modport)
//   game_state  : 00 IDLE, 01 RUN, 10 PAUSE
//   start_pulse : one-cycle pulse on IDLE->RUN
//   overflow    : sticky, a push was dropped because the queue was full
module key_cmd_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 5_000_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  key_cmd_scheduler_if.slave   bus,
  output logic [1:0]           game_state,
  output logic                 start_pulse,
  output logic                 overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int COUNT_W = PTR_W + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  localparam logic [RPT_W-1:0] DELAY_LOAD  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LOAD = RPT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  logic [1:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [COUNT_W-1:0] fifo_count;

  logic               held_valid;
  logic [1:0]         held_dir;
  logic [RPT_W-1:0]   rpt_cnt;

  logic       make_ev, break_ev;
  logic       is_dir, held_down;
  logic [1:0] ev_dir;
  logic       key_enter, key_p, key_esc;
  logic       in_run, in_pause, go_idle;
  logic       key_push, rpt_push, push, push_ok, pop, full, held_release;
  logic [1:0] push_dir;

  assign make_ev   = bus.key_valid &  bus.key_down[bus.last_change];
  assign break_ev  = bus.key_valid & ~bus.key_down[bus.last_change];
  assign key_enter = (bus.last_change == 9'h05A);
  assign key_p     = (bus.last_change == 9'h04D);
  assign key_esc   = (bus.last_change == 9'h076);
  assign in_run    = (game_state == ST_RUN);
  assign in_pause  = (game_state == ST_PAUSE);

  // Each direction has an extended arrow code and a WASD-style letter code.
  always_comb begin
    is_dir = 1'b1;
    ev_dir = DIR_UP;
    case (bus.last_change)
      9'h175, 9'h01D: ev_dir = DIR_UP;
      9'h172, 9'h01B: ev_dir = DIR_DOWN;
      9'h16B, 9'h01C: ev_dir = DIR_LEFT;
      9'h174, 9'h023: ev_dir = DIR_RIGHT;
      default:        is_dir = 1'b0;
    endcase
  end

  // The held direction stays alive while either of its two keys is still
  // down, so releasing one of a pair does not stop auto-repeat.
  always_comb begin
    held_down = 1'b0;
    case (held_dir)
      DIR_UP:    held_down = bus.key_down[9'h175] | bus.key_down[9'h01D];
      DIR_DOWN:  held_down = bus.key_down[9'h172] | bus.key_down[9'h01B];
      DIR_LEFT:  held_down = bus.key_down[9'h16B] | bus.key_down[9'h01C];
      default:   held_down = bus.key_down[9'h174] | bus.key_down[9'h023];
    endcase
  end

  // A fresh key press takes priority over a repeat expiring in the same cycle.
  assign key_push     = make_ev & is_dir & in_run;
  assign rpt_push     = in_run & held_valid & (rpt_cnt == '0) & ~key_push;
  assign push         = key_push | rpt_push;
  assign push_dir     = key_push ? ev_dir : held_dir;
  assign full         = (fifo_count == COUNT_W'(FIFO_DEPTH));
  assign pop          = bus.cmd_valid & bus.cmd_ready;
  assign push_ok      = push & (~full | pop);
  assign go_idle      = make_ev & key_esc & (in_run | in_pause);
  assign held_release = break_ev & is_dir & held_valid & (ev_dir == held_dir) & ~held_down;

  assign bus.cmd_valid = (fifo_count != '0) & in_run;
  assign bus.cmd_dir   = (fifo_count != '0) ? fifo_mem[rd_ptr] : 2'b00;

  // Game state machine; only make events of control keys move it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      game_state  <= ST_IDLE;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      if (make_ev) begin
        case (game_state)
          ST_IDLE: begin
            if (key_enter) begin
              game_state  <= ST_RUN;
              start_pulse <= 1'b1;
            end
          end
          ST_RUN: begin
            if (key_p)        game_state <= ST_PAUSE;
            else if (key_esc) game_state <= ST_IDLE;
          end
          ST_PAUSE: begin
            if (key_p)        game_state <= ST_RUN;
            else if (key_esc) game_state <= ST_IDLE;
          end
          default: game_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Held direction and repeat countdown. The counter only moves in RUN, so
  // a pause freezes the remaining time until the next repeat.
  always_ff @(posedge clk) begin
    if (!rst || go_idle) begin
      held_valid <= 1'b0;
      held_dir   <= DIR_UP;
      rpt_cnt    <= '0;
    end else if (key_push) begin
      held_valid <= 1'b1;
      held_dir   <= ev_dir;
      rpt_cnt    <= DELAY_LOAD;
    end else begin
      if (held_release) held_valid <= 1'b0;
      if (in_run && held_valid) begin
        rpt_cnt <= (rpt_cnt == '0) ? PERIOD_LOAD : rpt_cnt - RPT_W'(1);
      end
    end
  end

  // Queue bookkeeping; returning to IDLE discards everything queued.
  always_ff @(posedge clk) begin
    if (!rst || go_idle) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      fifo_count <= fifo_count + COUNT_W'(1);
      else if (!push_ok && pop) fifo_count <= fifo_count - COUNT_W'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_dir;
  end

endmodule
